// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin grant locked for a whole packet, one-entry holding register toward
// the transmitter, and an optional stall timeout that releases a stuck lock.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [1:0]           grant,
  output logic                 locked,
  output logic                 timeout_pulse
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q;
  logic [1:0]        rr_ptr_q;
  logic [CntW-1:0]   idle_cnt_q;

  // Requester buses padded to the 4-requester maximum so a 2-bit index always fits.
  logic [3:0]        valid_pad;
  logic [3:0]        last_pad;
  logic [31:0]       data_pad;
  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic              can_take;
  logic              accept;
  logic              found;
  logic [1:0]        pick;
  logic [2:0]        cand;
  logic [1:0]        rr_after;
  logic              timeout_hit;

  assign valid_pad = 4'(req_valid);
  assign last_pad  = 4'(req_last);
  assign data_pad  = 32'(req_data);

  // Select the owner's request signals and decide whether a byte moves this cycle.
  always_comb begin
    sel_valid   = valid_pad[grant];
    sel_last    = last_pad[grant];
    sel_data    = data_pad[{grant, 3'b000} +: 8];
    locked      = (state_q == StLocked);
    can_take    = en & (~tx_valid | tx_ready);
    accept      = locked & can_take & sel_valid;
    rr_after    = (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;
    timeout_hit = (TIMEOUT != 0) && (idle_cnt_q == CntW'(TIMEOUT - 1));
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = locked & can_take & (grant == 2'(i));
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && valid_pad[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  // Arbitration FSM, holding register and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant         <= '0;
      idle_cnt_q    <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;

      // The held byte drains independently of en and arbitration state.
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= sel_data;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (en && found) begin
            grant      <= pick;
            idle_cnt_q <= '0;
            state_q    <= StLocked;
          end
        end
        StLocked: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (accept) begin
            idle_cnt_q <= '0;
            if (sel_last) begin
              state_q  <= StIdle;
              rr_ptr_q <= rr_after;
            end
          end else begin
            if (idle_cnt_q != '1) idle_cnt_q <= idle_cnt_q + CntW'(1);
            if (timeout_hit) begin
              state_q       <= StIdle;
              rr_ptr_q      <= rr_after;
              timeout_pulse <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a packet-level reference model predicts the
// control outputs each cycle and queues expected bytes; a monitor checks every byte
// the DUT hands to the transmitter against that queue.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int NPH = 6;
  localparam int PHASE_CYC = 300;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [1:0]     grant;
  logic           locked;
  logic           timeout_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bytes = 0;
  int n_timeouts = 0;
  logic [7:0] exp_q[$];

  // Reference model state: who owns the transmitter, where the next search starts,
  // how long the owner has stalled, and whether a byte is waiting for the transmitter.
  bit m_locked = 0;
  int m_grant  = 0;
  int m_rr     = 0;
  int m_stall  = 0;
  bit m_held   = 0;
  bit m_pulse  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant        (grant),
    .locked       (locked),
    .timeout_pulse(timeout_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transmitter handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      check("tx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        n_bytes++;
      end
    end
  end

  // Reference model: compare this cycle's outputs, then advance one clock.
  always @(negedge clk) begin
    logic [N-1:0] er;
    bit acc;
    bit nxt_pulse;
    bit found;
    int idx;
    er = '0;
    if (m_locked && en && (!m_held || tx_ready)) er[m_grant] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("locked", 32'(locked), 32'(m_locked));
    check("tx_valid", 32'(tx_valid), 32'(m_held));
    check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    check("grant", 32'(grant), 32'(m_grant));

    nxt_pulse = 0;
    if (rst) begin
      m_locked = 0; m_grant = 0; m_rr = 0; m_stall = 0; m_held = 0;
      exp_q.delete();
    end else begin
      acc = er[m_grant] && req_valid[m_grant];
      if (acc) exp_q.push_back(req_data[8*m_grant +: 8]);
      if (acc) m_held = 1;
      else if (tx_ready) m_held = 0;

      if (!m_locked) begin
        if (en && (|req_valid)) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!found && req_valid[idx]) begin
              found = 1;
              m_grant = idx;
            end
          end
          m_locked = 1;
          m_stall  = 0;
        end
      end else if (!en) begin
        m_locked = 0;
      end else if (acc) begin
        m_stall = 0;
        if (req_last[m_grant]) begin
          m_locked = 0;
          m_rr = (m_grant + 1) % N;
        end
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_locked = 0;
          m_rr = (m_grant + 1) % N;
          nxt_pulse = 1;
          n_timeouts++;
        end
      end
    end
    m_pulse = nxt_pulse;
  end

  // Stimulus: phases of idle, streaming, backpressure, sparse (timeout),
  // en toggling, and occasional mid-packet reset.
  int pv[NPH]   = '{0,   90,  60, 12, 80, 70};
  int pr[NPH]   = '{100, 100, 40, 100, 70, 80};
  int pen[NPH]  = '{100, 100, 100, 100, 85, 100};
  int prst[NPH] = '{0,   0,   0,  0,  0,  2};
  int plast[NPH] = '{30, 50,  30, 60, 35, 35};

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int ph = 0; ph < NPH; ph++) begin
      for (int c = 0; c < PHASE_CYC; c++) begin
        rst      = ($urandom_range(99) < prst[ph]);
        en       = ($urandom_range(99) < pen[ph]);
        tx_ready = ($urandom_range(99) < pr[ph]);
        for (int i = 0; i < N; i++) begin
          req_valid[i]       = ($urandom_range(99) < pv[ph]);
          req_last[i]        = ($urandom_range(99) < plast[ph]);
          req_data[8*i +: 8] = 8'($urandom);
        end
        @(posedge clk);
        #1;
      end
    end
    // Drain whatever is still held, with no new requests.
    rst = 1'b0; en = 1'b1; req_valid = '0; req_last = '0; tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("timeouts_exercised", 32'(n_timeouts > 0), 32'd1);
    check("bytes_exercised", 32'(n_bytes > 50), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
